// File: rtl/sad_stream_engine.sv
// sad_stream_engine
// Streaming sum-of-absolute-differences engine. Each beat carries LANES pixel
// pairs. A block of BLK_PIX pixels forms one candidate. The engine emits every
// candidate's SAD on a result handshake. After NUM_CAND candidates it reports
// the minimum SAD and the index of that candidate.
// Pipeline: beat handshake -> stage 1 (per-lane |a-b|) -> stage 2 (lane sum
// added into the accumulator; the candidate completes here).
// Optional feature: define SAD_EARLY_TERM_EN to enable early termination. A
// candidate whose partial SAD reaches the best SAD so far stops accumulating.
module sad_stream_engine #(
    parameter int  PIX_W    = 8,
    parameter int  LANES    = 4,
    parameter int  BLK_PIX  = 256,
    parameter int  NUM_CAND = 16,
    localparam int BEATS    = BLK_PIX / LANES,
    localparam int SAD_W    = PIX_W + $clog2(BLK_PIX),
    localparam int IDX_W    = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*PIX_W-1:0] in_a,
    input  logic [LANES*PIX_W-1:0] in_b,
    output logic                   cand_valid,
    input  logic                   cand_ready,
    output logic [SAD_W-1:0]       cand_sad,
    output logic [IDX_W-1:0]       cand_idx,
    output logic                   cand_term,
    output logic                   best_valid,
    output logic [SAD_W-1:0]       best_sad,
    output logic [IDX_W-1:0]       best_idx,
    output logic                   busy
);
    localparam int                BEAT_W    = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [IDX_W-1:0]  LAST_CAND = IDX_W'(NUM_CAND - 1);
    localparam logic [IDX_W:0]    ALL_CAND  = (IDX_W + 1)'(NUM_CAND);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [IDX_W:0]      in_cand_q, in_cand_d;     // candidates fully accepted on the input side
    logic [PIX_W-1:0]    diff_q [LANES];
    logic [PIX_W-1:0]    diff_d [LANES];
    logic                s1_valid_q, s1_valid_d;
    logic                s1_last_q, s1_last_d;
    logic [SAD_W-1:0]    acc_q, acc_d;
    logic                term_q, term_d;           // current candidate already terminated
    logic [IDX_W-1:0]    cand_cnt_q, cand_cnt_d;   // index of the candidate in stage 2
    logic                cand_valid_q, cand_valid_d;
    logic [SAD_W-1:0]    cand_sad_q, cand_sad_d;
    logic [IDX_W-1:0]    cand_idx_q, cand_idx_d;
    logic                cand_term_q, cand_term_d;
    logic                best_valid_q, best_valid_d;
    logic [SAD_W-1:0]    best_sad_q, best_sad_d;
    logic [IDX_W-1:0]    best_idx_q, best_idx_d;
    logic                busy_q, busy_d;

    logic [PIX_W-1:0]    diff_new [LANES];
    logic [SAD_W-1:0]    tree_sum;
    logic [SAD_W-1:0]    acc_sum;
    logic [SAD_W-1:0]    eff_sad;                  // accumulator value after this beat
    logic                eff_term;                 // candidate terminated after this beat
    logic                hs;

    // Input accepts only while running. It stalls while a result is waiting to
    // be taken. It also stalls once every candidate's beats have been accepted.
    assign in_ready = (state_q == ST_RUN)
                   && !(cand_valid_q && !cand_ready)
                   && (in_cand_q != ALL_CAND);
    assign hs = in_valid && in_ready;

    // Per-lane absolute difference of the incoming beat.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [PIX_W-1:0] a_pix;
            logic [PIX_W-1:0] b_pix;
            assign a_pix        = in_a[gi*PIX_W +: PIX_W];
            assign b_pix        = in_b[gi*PIX_W +: PIX_W];
            assign diff_new[gi] = (a_pix >= b_pix) ? (a_pix - b_pix) : (b_pix - a_pix);
        end
    endgenerate

    // Sum the registered lane differences of stage 1 into one beat total.
    always_comb begin
        tree_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            tree_sum = tree_sum + SAD_W'(diff_q[k]);
        end
    end

    assign acc_sum = acc_q + tree_sum;

`ifdef SAD_EARLY_TERM_EN
    logic term_hit;

    // Early termination: a non-first candidate stops once it can no longer win.
    always_comb begin
        term_hit = !term_q && (cand_cnt_q != '0) && (acc_sum >= best_sad_q);
        eff_term = term_q || term_hit;
        eff_sad  = term_q ? acc_q : acc_sum;
    end
`else
    // No early termination: every beat accumulates.
    always_comb begin
        eff_term = 1'b0;
        eff_sad  = acc_sum;
    end
`endif

    // Next-state logic for the control FSM, the pipeline and the result registers.
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        in_cand_d    = in_cand_q;
        diff_d       = diff_q;
        s1_valid_d   = 1'b0;
        s1_last_d    = 1'b0;
        acc_d        = acc_q;
        term_d       = term_q;
        cand_cnt_d   = cand_cnt_q;
        cand_valid_d = cand_valid_q;
        cand_sad_d   = cand_sad_q;
        cand_idx_d   = cand_idx_q;
        cand_term_d  = cand_term_q;
        best_valid_d = 1'b0;
        best_sad_d   = best_sad_q;
        best_idx_d   = best_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    beat_cnt_d = '0;
                    in_cand_d  = '0;
                    cand_cnt_d = '0;
                    acc_d      = '0;
                    term_d     = 1'b0;
                    best_sad_d = '1;
                    best_idx_d = '0;
                end
            end

            ST_RUN: begin
                // Stage 1 capture and beat counting.
                if (hs) begin
                    diff_d     = diff_new;
                    s1_valid_d = 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        s1_last_d  = 1'b1;
                        in_cand_d  = in_cand_q + 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end

                // Result handshake; the last candidate's handshake ends the search.
                if (cand_valid_q && cand_ready) begin
                    cand_valid_d = 1'b0;
                    if (cand_idx_q == LAST_CAND) begin
                        state_d      = ST_DONE;
                        best_valid_d = 1'b1;
                    end
                end

                // Stage 2: accumulate. On the last beat, publish the candidate and clear.
                if (s1_valid_q) begin
                    if (s1_last_q) begin
                        cand_valid_d = 1'b1;
                        cand_sad_d   = eff_sad;
                        cand_idx_d   = cand_cnt_q;
                        cand_term_d  = eff_term;
                        cand_cnt_d   = cand_cnt_q + 1'b1;
                        acc_d        = '0;
                        term_d       = 1'b0;
                        if (!eff_term && (eff_sad < best_sad_q)) begin
                            best_sad_d = eff_sad;
                            best_idx_d = cand_cnt_q;
                        end
                    end else begin
                        acc_d  = eff_sad;
                        term_d = eff_term;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and pipeline registers; reset discards any search in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            beat_cnt_q   <= '0;
            in_cand_q    <= '0;
            for (int k = 0; k < LANES; k++) begin
                diff_q[k] <= '0;
            end
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            acc_q        <= '0;
            term_q       <= 1'b0;
            cand_cnt_q   <= '0;
            cand_valid_q <= 1'b0;
            cand_sad_q   <= '0;
            cand_idx_q   <= '0;
            cand_term_q  <= 1'b0;
            best_valid_q <= 1'b0;
            best_sad_q   <= '0;
            best_idx_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            in_cand_q    <= in_cand_d;
            diff_q       <= diff_d;
            s1_valid_q   <= s1_valid_d;
            s1_last_q    <= s1_last_d;
            acc_q        <= acc_d;
            term_q       <= term_d;
            cand_cnt_q   <= cand_cnt_d;
            cand_valid_q <= cand_valid_d;
            cand_sad_q   <= cand_sad_d;
            cand_idx_q   <= cand_idx_d;
            cand_term_q  <= cand_term_d;
            best_valid_q <= best_valid_d;
            best_sad_q   <= best_sad_d;
            best_idx_q   <= best_idx_d;
            busy_q       <= busy_d;
        end
    end

    assign cand_valid = cand_valid_q;
    assign cand_sad   = cand_sad_q;
    assign cand_idx   = cand_idx_q;
    assign cand_term  = cand_term_q;
    assign best_valid = best_valid_q;
    assign best_sad   = best_sad_q;
    assign best_idx   = best_idx_q;
    assign busy       = busy_q;

endmodule

// File: doc/sad_stream_engine.md
# sad_stream_engine

Parametrised successor to the single-lane SAD datapath. Accepts a valid/ready stream of LANES pixel pairs per beat and accumulates |A−B| over one block per candidate. Emits each candidate's SAD on a result handshake and reports the minimum SAD and its index over a full search of NUM_CAND candidates. Sits between the reference/candidate pixel FIFOs and the motion-vector selection logic.

## Interface
Parameters:
- PIX_W, 8: pixel width in bits.
- LANES, 4: pixel pairs per beat (power of 2).
- BLK_PIX, 256: pixels per block. Must be a multiple of LANES, and BLK_PIX/LANES ≥ 4.
- NUM_CAND, 16: candidates per search (≥1).
- Derived: BEATS = BLK_PIX/LANES; SAD_W = PIX_W + clog2(BLK_PIX); IDX_W = max(1, clog2(NUM_CAND)).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a search; sampled only in IDLE.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accept.
- in_a  in  LANES*PIX_W  reference pixels; lane k = bits [k*PIX_W +: PIX_W]; unsigned.
- in_b  in  LANES*PIX_W  candidate pixels; same packing.
- cand_valid  out  1  per-candidate result valid.
- cand_ready  in  1  per-candidate result accept.
- cand_sad  out  SAD_W  candidate SAD.
- cand_idx  out  IDX_W  candidate index (0..NUM_CAND-1).
- cand_term  out  1  candidate was early-terminated (see Configuration).
- best_valid  out  1  one-cycle pulse at end of search.
- best_sad  out  SAD_W  minimum SAD of the search.
- best_idx  out  IDX_W  index of the minimum.
- busy  out  1  high in RUN and DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on start=1. Actions on entry:
  - beat_cnt=0, cand_cnt=0
  - best_sad = all ones, best_idx = 0
  - accumulator = 0
- Stage 1 (registered on the beat handshake): per-lane absolute differences |a−b|, PIX_W bits unsigned.
- Stage 2 (registered): adder tree over the lanes; the sum is added to an SAD_W accumulator. The accumulator cannot overflow.
- Beat counting: beat_cnt increments on each handshake. On beat BEATS−1 it wraps to 0 and tags that beat "last".
- When the last beat exits stage 2:
  - Final sum is loaded into cand_sad/cand_idx; cand_valid is set.
  - Accumulator clears in the same cycle, so the next candidate's first beat adds to 0.
  - cand_cnt increments.
- Best update happens on the same completion. If cand_sad < best_sad (strict), best_sad/best_idx are updated. Ties keep the lower index.
- cand_valid holds, with stable data, until cand_ready=1.
- in_ready = (state==RUN) && !(cand_valid && !cand_ready) && (not all NUM_CAND candidates' beats already accepted).
- RUN → DONE when the final candidate's result handshakes (cand_valid && cand_ready).
- DONE: best_valid=1 for exactly one cycle; then → IDLE. best_sad/best_idx hold until the next start.
- start in RUN or DONE is ignored.
- Reset mid-search: all state is discarded immediately; no result is emitted.

## Timing
- Reset values:
  - in_ready=0, cand_valid=0, cand_sad=0, cand_idx=0, cand_term=0
  - best_valid=0, best_sad=0, best_idx=0, busy=0
  - state=IDLE
- in_ready first rises the cycle after start is sampled.
- Latency: last beat handshake at cycle t → cand_valid=1 at t+2.
- Throughput: 1 beat/cycle; no bubbles between candidates while cand_ready=1.
- Backpressure: while cand_valid && !cand_ready, in_ready=0. The ≤2 in-flight beats continue into the next candidate's accumulator. This is safe because BEATS ≥ 4.
- best_valid: asserted the cycle after the final cand handshake. busy falls with the return to IDLE, one cycle later.

## Configuration
- Macro: SAD_EARLY_TERM_EN.
- Defined: for cand_idx>0, once accumulator ≥ best_sad the candidate is terminated.
  - Remaining beats are still accepted at full rate but not accumulated.
  - Result is reported with cand_sad = accumulator value at termination and cand_term=1.
  - A terminated candidate never updates best.
- Not defined: cand_term is tied 0 and every candidate accumulates all BEATS beats.

## Test plan
- Reset then idle: rst=0 then 1, no start → all outputs 0, in_ready=0.
- Defaults, NUM_CAND=2:
  - cand0: a=0x10, b=0x08 all pixels → cand_sad=2048, cand_valid 2 cycles after beat 63.
  - cand1: a=b → cand_sad=0, best_idx=1, best_sad=0, best_valid pulse.
- Max value: a=0xFF, b=0x00 for all 256 pixels → cand_sad=65280, no overflow.
- Tie and backpressure:
  - Three candidates, each SAD 100, best_idx=0.
  - Hold cand_ready=0 for 10 cycles after cand0 → in_ready low, cand data stable, no beat lost.
- Reset mid-search: assert rst at beat 30 of cand1 → outputs return to reset values; a new start yields the correct SADs.
- With SAD_EARLY_TERM_EN:
  - cand0 SAD=50; cand1 diff 1 per pixel.
  - cand1 terminates when the accumulator reaches ≥50: cand_term=1, cand_sad=52 (13th beat, 4 lanes).
  - best unchanged (best_sad=50, best_idx=0).
